// File: rtl/eth_rx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_buf
// Description : Receive frame buffer; stores bytes in a circular buffer,
//               commits CRC/type-accepted frames, streams them FCS-stripped.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_buf #(
    parameter int pADDR_W     = 11,
    parameter int pDESC_DEPTH = 8,
    parameter int pCRC_WAIT   = 4,
    parameter int pMIN_LEN    = 5
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_En,
    input  logic        Byte_Rdy,
    input  logic [7:0]  Byte,
    input  logic        Crc_Valid,
    input  logic        EtherType_Valid,
    output logic [7:0]  Rd_Data,
    output logic        Rd_Valid,
    input  logic        Rd_Ready,
    output logic        Rd_Last,
    output logic [15:0] Frame_Cnt,
    output logic [15:0] Drop_Cnt,
    output logic        Buf_Full
);
    localparam int c_DEPTH  = 2 ** pADDR_W;
    localparam int c_DESC_W = (pDESC_DEPTH > 1) ? $clog2(pDESC_DEPTH) : 1;
    localparam int c_WAIT_W = (pCRC_WAIT > 1) ? $clog2(pCRC_WAIT) : 1;
    localparam logic [pADDR_W:0]  c_FULL     = (pADDR_W+1)'(c_DEPTH);
    localparam logic [pADDR_W:0]  c_FCS_SKIP = (pADDR_W+1)'(5);
    localparam logic [c_DESC_W:0] c_DESC_MAX = (c_DESC_W+1)'(pDESC_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_WAIT, W_DONE} wstate_t;
    typedef enum logic [0:0] {R_IDLE, R_STREAM} rstate_t;

    wstate_t             r_wstate;
    rstate_t             r_rstate;
    logic                r_rx_en_d;
    logic [pADDR_W:0]    r_wr_ptr;
    logic [pADDR_W:0]    r_commit_ptr;
    logic [pADDR_W:0]    r_rd_ptr;
    logic [15:0]         r_frm_len;
    logic                r_ovf;
    logic                r_rej;
    logic                r_good;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [15:0]         r_frame_cnt;
    logic [15:0]         r_drop_cnt;
    logic [7:0]          r_mem [c_DEPTH];
    logic [15:0]         r_desc_len [pDESC_DEPTH];
    logic [c_DESC_W-1:0] r_desc_wr;
    logic [c_DESC_W-1:0] r_desc_rd;
    logic [c_DESC_W:0]   r_desc_cnt;
    logic [15:0]         r_rem;
    logic                r_rd_valid;
    logic                r_rd_last;

    logic [pADDR_W:0]    w_used;
    logic                w_full;
    logic                w_wr_en;
    logic                w_commit;
    logic                w_pop;

    assign w_used   = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_used == c_FULL);
    assign w_wr_en  = (r_wstate == W_RECV) && Byte_Rdy && !w_full;
    assign w_commit = (r_wstate == W_DONE) && r_good && !r_rej && !r_ovf &&
                      (r_frm_len >= 16'(pMIN_LEN)) && (r_desc_cnt != c_DESC_MAX);
    assign w_pop    = (r_rstate == R_STREAM) && r_rd_valid && Rd_Ready && r_rd_last;

    assign Rd_Data   = r_mem[r_rd_ptr[pADDR_W-1:0]];
    assign Rd_Valid  = r_rd_valid;
    assign Rd_Last   = r_rd_last;
    assign Frame_Cnt = r_frame_cnt;
    assign Drop_Cnt  = r_drop_cnt;
    assign Buf_Full  = w_full;

    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[pADDR_W-1:0]] <= Byte;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_commit) begin
            r_desc_len[r_desc_wr] <= r_frm_len - 16'd4;
        end
    end

    // Descriptor queue bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_desc_wr  <= '0;
            r_desc_rd  <= '0;
            r_desc_cnt <= '0;
        end else begin
            if (w_commit) r_desc_wr <= r_desc_wr + 1'b1;
            if (w_pop)    r_desc_rd <= r_desc_rd + 1'b1;
            if (w_commit && !w_pop)      r_desc_cnt <= r_desc_cnt + 1'b1;
            else if (w_pop && !w_commit) r_desc_cnt <= r_desc_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wstate     <= W_IDLE;
            r_rx_en_d    <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_frm_len    <= '0;
            r_ovf        <= 1'b0;
            r_rej        <= 1'b0;
            r_good       <= 1'b0;
            r_wait_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_rx_en_d <= Rx_En;
            case (r_wstate)
                W_IDLE: begin
                    if (Rx_En && !r_rx_en_d) begin
                        r_wstate  <= W_RECV;
                        r_frm_len <= '0;
                        r_ovf     <= 1'b0;
                        r_rej     <= 1'b0;
                    end
                end
                W_RECV: begin
                    if (Byte_Rdy) begin
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_frm_len != 16'hFFFF) r_frm_len <= r_frm_len + 16'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (!EtherType_Valid) r_rej <= 1'b1;
                    if (!Rx_En) begin
                        r_wstate   <= W_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                W_WAIT: begin
                    if (Crc_Valid) begin
                        r_good   <= 1'b1;
                        r_wstate <= W_DONE;
                    end else if (r_wait_cnt == c_WAIT_W'(pCRC_WAIT - 1)) begin
                        r_good   <= 1'b0;
                        r_wstate <= W_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                W_DONE: begin
                    // A rejected frame is discarded by rewinding to the last commit point.
                    if (w_commit) begin
                        r_commit_ptr <= r_wr_ptr;
                        if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
                    end else begin
                        r_wr_ptr <= r_commit_ptr;
                        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rstate   <= R_IDLE;
            r_rd_ptr   <= '0;
            r_rem      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_desc_cnt != '0) begin
                        r_rem      <= r_desc_len[r_desc_rd];
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_desc_len[r_desc_rd] == 16'd1);
                        r_rstate   <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (Rd_Ready) begin
                        // The last handshake also skips the four stored FCS bytes.
                        if (r_rd_last) begin
                            r_rd_ptr   <= r_rd_ptr + c_FCS_SKIP;
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_rstate   <= R_IDLE;
                        end else begin
                            r_rd_ptr  <= r_rd_ptr + 1'b1;
                            r_rem     <= r_rem - 16'd1;
                            r_rd_last <= (r_rem == 16'd2);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_frame_buf
// Description : Directed self-checking bench for eth_rx_frame_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_frame_buf;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        Rx_En;
    logic        Byte_Rdy;
    logic [7:0]  Byte;
    logic        Crc_Valid;
    logic        EtherType_Valid;
    logic [7:0]  Rd_Data;
    logic        Rd_Valid;
    logic        Rd_Ready;
    logic        Rd_Last;
    logic [15:0] Frame_Cnt;
    logic [15:0] Drop_Cnt;
    logic        Buf_Full;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    eth_rx_frame_buf dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Rx_En           (Rx_En),
        .Byte_Rdy        (Byte_Rdy),
        .Byte            (Byte),
        .Crc_Valid       (Crc_Valid),
        .EtherType_Valid (EtherType_Valid),
        .Rd_Data         (Rd_Data),
        .Rd_Valid        (Rd_Valid),
        .Rd_Ready        (Rd_Ready),
        .Rd_Last         (Rd_Last),
        .Frame_Cnt       (Frame_Cnt),
        .Drop_Cnt        (Drop_Cnt),
        .Buf_Full        (Buf_Full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1; Rx_En = 1'b0; Byte_Rdy = 1'b0; Byte = 8'h00;
        Crc_Valid = 1'b0; EtherType_Valid = 1'b1; Rd_Ready = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Byte i of a frame is seed+i; Rx_En drops together with the last byte.
    task automatic send_frame(input int len, input logic [7:0] seed, input int crc_dly,
                              input int bad_et, input int gap);
        @(negedge Clk);
        Rx_En = 1'b1;
        for (int i = 0; i < len; i++) begin
            repeat (gap - 1) begin
                @(negedge Clk);
                Byte_Rdy = 1'b0;
            end
            @(negedge Clk);
            Byte_Rdy = 1'b1;
            Byte = seed + 8'(i);
            EtherType_Valid = (i != bad_et);
            if (i == len - 1) Rx_En = 1'b0;
        end
        @(negedge Clk);
        Byte_Rdy = 1'b0;
        EtherType_Valid = 1'b1;
        if (crc_dly > 0) begin
            repeat (crc_dly - 1) @(negedge Clk);
            Crc_Valid = 1'b1;
            @(negedge Clk);
            Crc_Valid = 1'b0;
        end
        repeat (6) @(negedge Clk);
    endtask

    task automatic recv_frame(input int len, input logic [7:0] seed, input bit rnd, input string tag);
        int got = 0;
        int bad = 0;
        int last_at = -1;
        int t = 0;
        while (got < len && t < 20000) begin
            @(negedge Clk);
            t++;
            Rd_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (Rd_Valid && Rd_Ready) begin
                if (Rd_Data !== seed + 8'(got)) bad++;
                if (Rd_Last && last_at < 0) last_at = got;
                got++;
            end
        end
        @(negedge Clk);
        Rd_Ready = 1'b0;
        check({tag, "_len"}, got, len);
        check({tag, "_data_errs"}, bad, 0);
        check({tag, "_last_pos"}, last_at, len - 1);
        check({tag, "_gap_valid"}, Rd_Valid, 0);
    endtask

    logic [7:0] wrap_seed [3] = '{8'h31, 8'h92, 8'hC5};

    initial begin
        do_reset();
        check("rst_valid", Rd_Valid, 0);
        check("rst_last", Rd_Last, 0);
        check("rst_frame_cnt", Frame_Cnt, 0);
        check("rst_drop_cnt", Drop_Cnt, 0);
        check("rst_full", Buf_Full, 0);

        // Good 64-byte frame
        send_frame(64, 8'h10, 2, -1, 1);
        check("good_frame_cnt", Frame_Cnt, 1);
        check("good_drop_cnt", Drop_Cnt, 0);
        check("good_commit_ptr", dut.r_commit_ptr, 64);
        recv_frame(60, 8'h10, 1'b0, "good");
        check("good_rd_ptr", dut.r_rd_ptr, 64);

        // Missing CRC pulse
        do_reset();
        send_frame(64, 8'h10, 0, -1, 1);
        check("nocrc_wr_ptr", dut.r_wr_ptr, 0);
        check("nocrc_drop_cnt", Drop_Cnt, 1);
        check("nocrc_frame_cnt", Frame_Cnt, 0);
        check("nocrc_valid", Rd_Valid, 0);

        // EtherType rejected on byte 14, then a good frame lands at index 0
        do_reset();
        send_frame(64, 8'h55, 2, 13, 1);
        check("ety_drop_cnt", Drop_Cnt, 1);
        check("ety_wr_ptr", dut.r_wr_ptr, 0);
        send_frame(64, 8'h40, 2, -1, 1);
        check("ety_frame_cnt", Frame_Cnt, 1);
        recv_frame(60, 8'h40, 1'b0, "ety_next");

        // Buffer overflow with the reader stalled
        do_reset();
        send_frame(1000, 8'h01, 2, -1, 1);
        send_frame(1000, 8'h02, 2, -1, 1);
        send_frame(100, 8'h03, 2, -1, 1);
        check("ovf_frame_cnt", Frame_Cnt, 2);
        check("ovf_drop_cnt", Drop_Cnt, 1);
        check("ovf_wr_ptr", dut.r_wr_ptr, 2000);
        check("ovf_full_after", Buf_Full, 0);
        recv_frame(996, 8'h01, 1'b0, "ovf_f1");
        recv_frame(996, 8'h02, 1'b0, "ovf_f2");
        repeat (3) @(negedge Clk);
        check("ovf_no_third", Rd_Valid, 0);

        // Descriptor queue saturation
        do_reset();
        for (int f = 0; f < 9; f++) send_frame(64, 8'(f), 2, -1, 1);
        check("desc_frame_cnt", Frame_Cnt, 8);
        check("desc_drop_cnt", Drop_Cnt, 1);
        recv_frame(60, 8'h00, 1'b0, "desc_first");

        // Reset while a frame is arriving and another is streaming
        do_reset();
        send_frame(64, 8'h20, 2, -1, 1);
        @(negedge Clk);
        Rx_En = 1'b1;
        Rd_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            Byte_Rdy = 1'b1;
            Byte = 8'(i);
        end
        check("mid_valid", Rd_Valid, 1);
        Rst = 1'b1; Byte_Rdy = 1'b0; Rx_En = 1'b0; Rd_Ready = 1'b0;
        @(negedge Clk);
        check("mid_rst_valid", Rd_Valid, 0);
        check("mid_rst_last", Rd_Last, 0);
        check("mid_rst_frame_cnt", Frame_Cnt, 0);
        check("mid_rst_drop_cnt", Drop_Cnt, 0);
        check("mid_rst_full", Buf_Full, 0);
        Rst = 1'b0;
        send_frame(64, 8'h77, 2, -1, 1);
        recv_frame(60, 8'h77, 1'b0, "post_rst");
        check("post_rst_rd_ptr", dut.r_rd_ptr, 64);

        // Continuous long frames across pointer wrap with a jittery consumer
        do_reset();
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(1500, wrap_seed[f], 2, -1, 4);
            end
            begin
                for (int g = 0; g < 3; g++) recv_frame(1496, wrap_seed[g], 1'b1, "wrap");
            end
        join
        check("wrap_frame_cnt", Frame_Cnt, 3);
        check("wrap_drop_cnt", Drop_Cnt, 0);
        check("wrap_rd_ptr", dut.r_rd_ptr, 404);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
